ahb_read_fifo: RTL and testbench

- Single-clock first-word-fall-through buffer directly upstream of the JTAG AHB read-out stage.
- The AHB master side pushes read-data bytes into it.
- The read-out stage pops them with rinc while shifting the data onto TDO.
- Supplies the empty/rdata/rinc contract that stage consumes, plus occupancy and error status for the JTAG status register.

---
 rtl/jtag_types_pkg.sv | 11 +
 rtl/ahb_fifo_write_if.sv | 13 +
 rtl/fifo_ptr.sv | 29 ++
 rtl/ahb_read_fifo.sv | 99 +++++++++
 tb/tb_ahb_read_fifo.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/jtag_types_pkg.sv
// Shared types and sizing constants for the JTAG AHB read-out path.
package jtag_types_pkg;

   localparam int AHB_FIFO_DEPTH      = 8;
   localparam int AHB_FIFO_DATA_WIDTH = 8;
   localparam int AHB_FIFO_ADDR_WIDTH = $clog2(AHB_FIFO_DEPTH);

   // Extra MSB is the wrap bit that separates full from empty.
   typedef logic [AHB_FIFO_ADDR_WIDTH:0] fifo_ptr_t;

endpackage

// File: rtl/ahb_fifo_write_if.sv
// Write-side bundle between the AHB master and the read-data FIFO.
interface ahb_fifo_write_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic [DATA_WIDTH-1:0] wdata;
   logic                  winc;
   logic                  full;

   modport FIFO (input wdata, input winc, output full);
   modport TB   (output wdata, output winc, input full);

endinterface

// File: rtl/fifo_ptr.sv
// FIFO pointer register: index plus wrap bit, with synchronous clear.
module fifo_ptr #(
   parameter int ADDR_WIDTH = 3
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                flush,
   input  logic                inc,
   output logic [ADDR_WIDTH:0] ptr
);

   logic [ADDR_WIDTH:0] ptr_r;

   // Pointer update; the index rolls over into the wrap bit naturally.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_r <= {(ADDR_WIDTH+1){1'b0}};
      end else if (flush) begin
         ptr_r <= {(ADDR_WIDTH+1){1'b0}};
      end else if (inc) begin
         ptr_r <= ptr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr = ptr_r;

endmodule

// File: rtl/ahb_read_fifo.sv
// First-word-fall-through buffer between the AHB master and the JTAG read-out
// stage, with occupancy and sticky overflow/underflow status.
module ahb_read_fifo
   import jtag_types_pkg::*;
#(
   parameter int DATA_WIDTH = AHB_FIFO_DATA_WIDTH,
   parameter int DEPTH      = AHB_FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  flush,
   ahb_fifo_write_if.FIFO        wr,
   input  logic                  rinc,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR_WIDTH:0]   wptr_s;
   logic [ADDR_WIDTH:0]   rptr_s;
   logic                  empty_s;
   logic                  full_s;
   logic                  wr_accept_s;
   logic                  rd_accept_s;
   logic                  ovf_set_s;
   logic                  unf_set_s;
   logic                  overflow_r;
   logic                  underflow_r;

   assign empty_s = (wptr_s == rptr_s);
   assign full_s  = (wptr_s[ADDR_WIDTH-1:0] == rptr_s[ADDR_WIDTH-1:0]) &&
                    (wptr_s[ADDR_WIDTH] != rptr_s[ADDR_WIDTH]);

   // Accept/reject decisions; a pop on a full FIFO frees the slot for the write.
   always_comb begin
      wr_accept_s = 1'b0;
      rd_accept_s = 1'b0;
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      if (!flush) begin
         wr_accept_s = wr.winc && (!full_s || rinc);
         rd_accept_s = rinc && !empty_s;
         ovf_set_s   = wr.winc && full_s && !rinc;
         unf_set_s   = rinc && empty_s;
      end else begin
         wr_accept_s = 1'b0;
         rd_accept_s = 1'b0;
      end
   end

   fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
      .CLK   (CLK),
      .RST   (RST),
      .flush (flush),
      .inc   (wr_accept_s),
      .ptr   (wptr_s)
   );

   fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
      .CLK   (CLK),
      .RST   (RST),
      .flush (flush),
      .inc   (rd_accept_s),
      .ptr   (rptr_s)
   );

   // Storage array; intentionally not reset.
   always_ff @(posedge CLK) begin
      if (wr_accept_s && !RST) begin
         mem_r[wptr_s[ADDR_WIDTH-1:0]] <= wr.wdata;
      end
   end

   // Sticky error flags, cleared only by reset or flush.
   always_ff @(posedge CLK) begin
      if (RST) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (flush) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         overflow_r  <= overflow_r  | ovf_set_s;
         underflow_r <= underflow_r | unf_set_s;
      end
   end

   assign rdata     = mem_r[rptr_s[ADDR_WIDTH-1:0]];
   assign empty     = empty_s;
   assign wr.full   = full_s;
   assign count     = wptr_s - rptr_s;
   assign overflow  = overflow_r;
   assign underflow = underflow_r;

endmodule

// File: tb/tb_ahb_read_fifo.sv
// Self-checking bench for ahb_read_fifo: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_ahb_read_fifo;
   import jtag_types_pkg::*;

   localparam int DW = AHB_FIFO_DATA_WIDTH;
   localparam int DP = AHB_FIFO_DEPTH;

   logic          CLK;
   logic          RST;
   logic          flush;
   logic          rinc;
   logic [DW-1:0] rdata;
   logic          empty;
   fifo_ptr_t     count;
   logic          overflow;
   logic          underflow;

   ahb_fifo_write_if #(.DATA_WIDTH(DW)) wr ();

   ahb_read_fifo dut (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (flush),
      .wr        (wr.FIFO),
      .rinc      (rinc),
      .rdata     (rdata),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: contents as a queue plus sticky flags.
   logic [DW-1:0] q[$];
   logic          m_ovf;
   logic          m_unf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic f, input logic wi,
                             input logic [DW-1:0] wd, input logic ri);
      bit is_full;
      bit is_empty;
      if (r || f) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         is_full  = (q.size() == DP);
         is_empty = (q.size() == 0);
         if (wi && is_full && !ri) m_ovf = 1'b1;
         if (ri && is_empty) m_unf = 1'b1;
         if (ri && !is_empty) void'(q.pop_front());
         if (wi && (!is_full || ri)) q.push_back(wd);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
      check({tag, ".full"}, {31'd0, wr.full}, {31'd0, q.size() == DP});
      check({tag, ".count"}, {28'd0, count}, q.size());
      check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
      check({tag, ".unf"}, {31'd0, underflow}, {31'd0, m_unf});
      if (q.size() != 0) check({tag, ".rdata"}, {24'd0, rdata}, {24'd0, q[0]});
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later.
   task automatic step(input logic r, input logic f, input logic wi,
                       input logic [DW-1:0] wd, input logic ri, input string tag);
      RST = r; flush = f; wr.winc = wi; wr.wdata = wd; rinc = ri;
      @(posedge CLK);
      model_edge(r, f, wi, wd, ri);
      #1;
      RST = 1'b0; flush = 1'b0; wr.winc = 1'b0; rinc = 1'b0;
      check_model(tag);
   endtask

   typedef struct {
      logic          rst;
      logic          flush;
      logic          winc;
      logic [DW-1:0] wdata;
      logic          rinc;
      logic          exp_empty;
      logic          exp_full;
      logic [3:0]    exp_count;
      logic          chk_rdata;
      logic [DW-1:0] exp_rdata;
      logic          exp_ovf;
      logic          exp_unf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic f, logic wi, logic [DW-1:0] wd, logic ri,
                               logic e, logic fu, logic [3:0] c, logic cr,
                               logic [DW-1:0] rd, logic ov, logic un);
      vec_t v;
      v.rst = r; v.flush = f; v.winc = wi; v.wdata = wd; v.rinc = ri;
      v.exp_empty = e; v.exp_full = fu; v.exp_count = c; v.chk_rdata = cr;
      v.exp_rdata = rd; v.exp_ovf = ov; v.exp_unf = un;
      return v;
   endfunction

   initial begin
      RST = 1'b1; flush = 1'b0; wr.winc = 1'b0; wr.wdata = 8'h00; rinc = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0;

      //                r     f     wi    wd     ri    e     fu    cnt   cr    rd     ov    un
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 8'hA1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 8'hA1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 8'hA1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 8'hB2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 8'hC3, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 8'h3C, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h9E, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 8'h9E, 1'b0, 1'b0));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].flush, vecs[i].winc, vecs[i].wdata, vecs[i].rinc,
              $sformatf("vec%0d", i));
         check($sformatf("vec%0d.t_empty", i), {31'd0, empty}, {31'd0, vecs[i].exp_empty});
         check($sformatf("vec%0d.t_full", i), {31'd0, wr.full}, {31'd0, vecs[i].exp_full});
         check($sformatf("vec%0d.t_count", i), {28'd0, count}, {28'd0, vecs[i].exp_count});
         check($sformatf("vec%0d.t_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
         check($sformatf("vec%0d.t_unf", i), {31'd0, underflow}, {31'd0, vecs[i].exp_unf});
         if (vecs[i].chk_rdata)
            check($sformatf("vec%0d.t_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
      end

      // Overflow on full: dropped write, contents intact.
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "ovf.rst");
      for (int i = 0; i < DP; i++) step(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, "ovf.fill");
      step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, "ovf.push");
      check("ovf.full", {31'd0, wr.full}, 32'd1);
      check("ovf.flag", {31'd0, overflow}, 32'd1);
      check("ovf.count", {28'd0, count}, 32'd8);
      for (int i = 0; i < DP; i++) begin
         check("ovf.drain", {24'd0, rdata}, i);
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "ovf.pop");
      end

      // Simultaneous push and pop while full.
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "fp.rst");
      for (int i = 0; i < DP; i++) step(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, "fp.fill");
      step(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, "fp.both");
      check("fp.rdata", {24'd0, rdata}, 32'h01);
      check("fp.count", {28'd0, count}, 32'd8);
      check("fp.ovf", {31'd0, overflow}, 32'd0);
      for (int i = 1; i <= DP; i++) begin
         check("fp.drain", {24'd0, rdata}, (i == DP) ? 32'h55 : i);
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "fp.pop");
      end
      check("fp.empty", {31'd0, empty}, 32'd1);

      // Flush with a concurrent write, then restart at index 0.
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "fl.rst");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, "fl.fill");
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "fl.pop");
      step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, "fl.flush");
      check("fl.empty", {31'd0, empty}, 32'd1);
      check("fl.count", {28'd0, count}, 32'd0);
      step(1'b0, 1'b0, 1'b1, 8'h9E, 1'b0, "fl.write");
      check("fl.rdata", {24'd0, rdata}, 32'h9E);
      check("fl.count1", {28'd0, count}, 32'd1);

      // Interleaved write/pop pairs crossing two pointer wraps.
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "wr.rst");
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0, "wr.push");
         check("wrap.rdata", {24'd0, rdata}, 32'h40 + i);
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "wr.pop");
      end
      check("wrap.ovf", {31'd0, overflow}, 32'd0);
      check("wrap.unf", {31'd0, underflow}, 32'd0);

      // Randomized traffic against the model.
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "rnd.rst");
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(63) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(31) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(1)),
              8'($urandom),
              1'($urandom_range(1)),
              "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
